mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
Parametrised successor to the fixed 6-bit enable counter in the utility library. Adds configurable width and modulus, up/down counting, synchronous load and clear, wrap or saturate mode, and a sticky overflow flag. Used as the generic timing, index and loop counter for datapath controllers built from the utility cells.

Parameters:
WIDTH, 6, bit width of the count register (2..16).
MODULUS, 64, count range is 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
clr  input  1  synchronous clear of count and ovf.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  value to load.
en  input  1  count enable.
up_dn  input  1  1 = count up, 0 = count down.
cnt  output  WIDTH  current count, registered.
cout  output  1  terminal-count indicator, combinational.
ovf  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset: rst high asynchronously forces cnt=0 and ovf=0. cout then follows its combinational rule.
- Per-edge priority, applied when rst is low: clr > load > en > hold.
- clr: cnt <= 0, ovf <= 0, regardless of load/en.
- load: cnt <= load_val if load_val <= MODULUS-1, else cnt <= MODULUS-1 (clamp). ovf is unchanged.
- en without clr/load, counting up:
  - cnt < MODULUS-1: cnt <= cnt+1.
  - cnt == MODULUS-1: wraps to 0 (SATURATE=0) or holds (SATURATE=1).
- en without clr/load, counting down:
  - cnt > 0: cnt <= cnt-1.
  - cnt == 0: wraps to MODULUS-1 (SATURATE=0) or holds at 0 (SATURATE=1).
- Terminal definition: cnt == MODULUS-1 when up_dn=1, cnt == 0 when up_dn=0.
- cout = en & terminal. Zero latency and combinational, matching the legacy counter (cout=1 at 63 with en=1 for default parameters).
- ovf: set on any clock edge where en=1, clr=0, load=0 and terminal=1 (wrap or saturate attempt). Holds until clr or rst.
- Terminal handling is identical for MODULUS = 2**WIDTH and MODULUS < 2**WIDTH. Arithmetic is WIDTH bits, and an intermediate value never exceeds MODULUS-1.
- en=0 holds cnt; cout=0.
- up_dn may change on any cycle; the new direction takes effect on the next edge.
- Simultaneous load and en: load wins; no count step that cycle.
- rst asserted mid-count clears immediately, without waiting for a clock edge. Deassertion resumes counting from 0 on the first following edge with en=1.
- With default parameters, behaviour is cycle-identical to the legacy 6-bit counter when up_dn=1, clr=0, load=0.

Decomposition:
- Shared package holds:
  - direction constants DIR_UP=1'b1 and DIR_DN=1'b0.
  - mode constants MODE_WRAP=0 and MODE_SAT=1.
- One sub-module, mod_counter_next. It is purely combinational: it computes the next count and the terminal flag from cnt, up_dn and the parameters.
- The top-level module holds the register, the priority muxing and ovf.

Test Plan:
- Default params, rst pulse then en=1, up_dn=1: cnt steps 0..63. At cnt=63, cout=1. Next edge gives cnt=0 and ovf=1. clr then gives cnt=0, ovf=0.
- WIDTH=4, MODULUS=10, up: cnt sequence 0..9,0. cout=1 only while cnt=9 and en=1. Set en=0 at cnt=9: cout=0 and cnt holds 9.
- WIDTH=4, MODULUS=10, down from load_val=2: sequence 2,1,0,9. cout=1 at cnt=0. ovf=1 after the wrap.
- SATURATE=1, MODULUS=10: count up to 9 and hold 9 for 3 more en cycles, with ovf=1. Switch up_dn=0: 8,7,...,0, then hold at 0.
- Priority: load=1, load_val=5, en=1 on the same edge gives cnt=5. load_val=12 with MODULUS=10 gives cnt=9. clr=1 with load=1 gives cnt=0.
- Async reset: at cnt=7, pulse rst for 3 ns between clock edges. cnt=0 and ovf=0 immediately, before the next edge. Counting resumes 0,1,2.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared constants for the parametrised modulo counter and its next-state
// helper. Direction and mode encodings are kept here so that controllers
// driving the counter and the counter itself agree on the meaning of up_dn
// and of the SATURATE parameter.
// -----------------------------------------------------------------------------
package mod_counter_pkg;

  // Counting direction as seen on the up_dn port.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Terminal behaviour selected by the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_next.sv
// -----------------------------------------------------------------------------
// mod_counter_next
// Purely combinational next-count and terminal-flag generator for mod_counter.
// It assumes the count is enable-qualified by the caller: it always reports
// the step that would be taken if counting were enabled this cycle.
//
// Ports:
//   cnt_i       current count (always within 0..MODULUS-1)
//   up_dn_i     direction, DIR_UP counts up, DIR_DN counts down
//   cnt_next_o  count after one enabled step (wrap or saturate applied)
//   terminal_o  count sits at the terminal value for the current direction
// -----------------------------------------------------------------------------
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 64,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             up_dn_i,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic             terminal_o
);

  // Largest legal count. Expressed in WIDTH bits so that MODULUS == 2**WIDTH
  // and MODULUS < 2**WIDTH take exactly the same comparison path.
  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_CNT = '0;
  localparam logic [WIDTH-1:0] ONE_CNT  = WIDTH'(1);

  logic atMax;
  logic atZero;

  assign atMax  = (cnt_i == MAX_CNT);
  assign atZero = (cnt_i == ZERO_CNT);

  // Terminal is direction dependent: top of range going up, zero going down.
  assign terminal_o = (up_dn_i == DIR_UP) ? atMax : atZero;

  // Next count. The increment/decrement is only taken away from the terminal,
  // so the raw WIDTH-bit arithmetic can never step outside 0..MODULUS-1 and
  // never relies on natural 2**WIDTH rollover.
  always_comb begin
    cnt_next_o = cnt_i;
    if (up_dn_i == DIR_UP) begin
      if (!atMax) begin
        cnt_next_o = cnt_i + ONE_CNT;
      end else if (SATURATE == MODE_SAT) begin
        cnt_next_o = cnt_i;
      end else begin
        cnt_next_o = ZERO_CNT;
      end
    end else begin
      if (!atZero) begin
        cnt_next_o = cnt_i - ONE_CNT;
      end else if (SATURATE == MODE_SAT) begin
        cnt_next_o = cnt_i;
      end else begin
        cnt_next_o = MAX_CNT;
      end
    end
  end

endmodule : mod_counter_next

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Parametrised up/down modulo counter with synchronous clear and load,
// wrap or saturate terminal behaviour, a combinational terminal-count output
// and a sticky overflow/underflow flag. With default parameters and
// up_dn=1, clr=0, load=0 it behaves exactly like the legacy 6-bit enable
// counter.
//
// Parameters:
//   WIDTH     count register width (2..16)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE  MODE_WRAP (0) wraps at terminal, MODE_SAT (1) holds
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (cnt=0, ovf=0)
//   clr       synchronous clear of cnt and ovf, highest edge priority
//   load      synchronous load of load_val (clamped to MODULUS-1)
//   load_val  value to load
//   en        count enable
//   up_dn     1 counts up, 0 counts down
//   cnt       registered count
//   cout      en & terminal, combinational
//   ovf       sticky flag, set by any enabled step taken at the terminal
// -----------------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 64,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] cnt,
  output logic             cout,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] step_cnt;
  logic             terminal;
  logic [WIDTH-1:0] load_clamped;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .cnt_i      (cnt_q),
    .up_dn_i    (up_dn),
    .cnt_next_o (step_cnt),
    .terminal_o (terminal)
  );

  // Out-of-range load values are clamped so the register never holds a
  // count the next-state logic was not designed for.
  assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  // Edge priority clr > load > en > hold. ovf only reacts to clr (clear) and
  // to an enabled step at the terminal; a load leaves it untouched.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = load_clamped;
    end else if (en) begin
      cnt_d = step_cnt;
      if (terminal) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign ovf  = ovf_q;
  assign cout = en & terminal;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Directed bench for mod_counter. Three instances share clock and reset:
//   dutA  default parameters (WIDTH=6, MODULUS=64, wrap)
//   dutB  WIDTH=4, MODULUS=10, wrap
//   dutC  WIDTH=4, MODULUS=10, saturate
// Inputs change #1 after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  logic clk;
  logic rst;

  logic       aClr, aLoad, aEn, aUp;
  logic [5:0] aLoadVal;
  logic [5:0] aCnt;
  logic       aCout, aOvf;

  logic       bClr, bLoad, bEn, bUp;
  logic [3:0] bLoadVal;
  logic [3:0] bCnt;
  logic       bCout, bOvf;

  logic       cClr, cLoad, cEn, cUp;
  logic [3:0] cLoadVal;
  logic [3:0] cCnt;
  logic       cCout, cOvf;

  int compared;
  int mismatched;

  mod_counter dutA (
    .clk(clk), .rst(rst), .clr(aClr), .load(aLoad), .load_val(aLoadVal),
    .en(aEn), .up_dn(aUp), .cnt(aCnt), .cout(aCout), .ovf(aOvf)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dutB (
    .clk(clk), .rst(rst), .clr(bClr), .load(bLoad), .load_val(bLoadVal),
    .en(bEn), .up_dn(bUp), .cnt(bCnt), .cout(bCout), .ovf(bOvf)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dutC (
    .clk(clk), .rst(rst), .clr(cClr), .load(cLoad), .load_val(cLoadVal),
    .en(cEn), .up_dn(cUp), .cnt(cCnt), .cout(cCout), .ovf(cOvf)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    aClr = 0; aLoad = 0; aEn = 0; aUp = 1; aLoadVal = '0;
    bClr = 0; bLoad = 0; bEn = 0; bUp = 1; bLoadVal = '0;
    cClr = 0; cLoad = 0; cEn = 0; cUp = 1; cLoadVal = '0;

    // Reset state.
    applyStimulus();
    applyStimulus();
    checkOutput("A reset cnt", 32'(aCnt), 0);
    checkOutput("A reset ovf", 32'(aOvf), 0);
    checkOutput("A reset cout", 32'(aCout), 0);
    checkOutput("B reset cnt", 32'(bCnt), 0);
    checkOutput("C reset ovf", 32'(cOvf), 0);
    rst = 1'b0;

    // Default counter: 0..63, cout at 63, wrap sets ovf, clr clears.
    aEn = 1; aUp = 1;
    for (int i = 0; i < 63; i++) begin
      checkOutput("A up cnt", 32'(aCnt), 32'(i));
      checkOutput("A up cout", 32'(aCout), 0);
      applyStimulus();
    end
    checkOutput("A at 63 cnt", 32'(aCnt), 63);
    checkOutput("A at 63 cout", 32'(aCout), 1);
    checkOutput("A at 63 ovf", 32'(aOvf), 0);
    applyStimulus();
    checkOutput("A wrap cnt", 32'(aCnt), 0);
    checkOutput("A wrap ovf", 32'(aOvf), 1);
    aClr = 1;
    applyStimulus();
    checkOutput("A clr cnt", 32'(aCnt), 0);
    checkOutput("A clr ovf", 32'(aOvf), 0);
    aClr = 0; aEn = 0;

    // MODULUS=10 wrap, counting up.
    bEn = 1; bUp = 1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("B up cnt", 32'(bCnt), 32'(i));
      checkOutput("B up cout", 32'(bCout), (i == 9) ? 1 : 0);
      applyStimulus();
    end
    checkOutput("B wrap cnt", 32'(bCnt), 0);
    checkOutput("B wrap ovf", 32'(bOvf), 1);
    for (int i = 0; i < 9; i++) applyStimulus();
    checkOutput("B back at 9", 32'(bCnt), 9);
    bEn = 0;
    #1;
    checkOutput("B en0 cout", 32'(bCout), 0);
    applyStimulus();
    checkOutput("B en0 hold", 32'(bCnt), 9);
    bClr = 1;
    applyStimulus();
    checkOutput("B clr ovf", 32'(bOvf), 0);
    bClr = 0;

    // MODULUS=10 wrap, counting down from 2.
    bLoad = 1; bLoadVal = 4'd2;
    applyStimulus();
    bLoad = 0; bEn = 1; bUp = 0;
    checkOutput("B dn load", 32'(bCnt), 2);
    checkOutput("B dn cout at 2", 32'(bCout), 0);
    applyStimulus();
    checkOutput("B dn 1", 32'(bCnt), 1);
    applyStimulus();
    checkOutput("B dn 0", 32'(bCnt), 0);
    checkOutput("B dn cout at 0", 32'(bCout), 1);
    checkOutput("B dn ovf pre", 32'(bOvf), 0);
    applyStimulus();
    checkOutput("B dn wrap 9", 32'(bCnt), 9);
    checkOutput("B dn ovf", 32'(bOvf), 1);

    // Priority: load over en, clamp, clr over load; load keeps ovf.
    bUp = 1; bLoad = 1; bLoadVal = 4'd5;
    applyStimulus();
    checkOutput("B load beats en", 32'(bCnt), 5);
    checkOutput("B load keeps ovf", 32'(bOvf), 1);
    bLoadVal = 4'd12;
    applyStimulus();
    checkOutput("B load clamp", 32'(bCnt), 9);
    bClr = 1;
    applyStimulus();
    checkOutput("B clr beats load", 32'(bCnt), 0);
    checkOutput("B clr beats load ovf", 32'(bOvf), 0);
    bClr = 0; bLoad = 0; bEn = 0;

    // Saturating counter: up to 9, hold, then down to 0 and hold.
    cEn = 1; cUp = 1;
    for (int i = 0; i < 9; i++) applyStimulus();
    checkOutput("C up 9", 32'(cCnt), 9);
    checkOutput("C up 9 cout", 32'(cCout), 1);
    checkOutput("C up 9 ovf", 32'(cOvf), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("C sat hold 9", 32'(cCnt), 9);
      checkOutput("C sat ovf", 32'(cOvf), 1);
    end
    cUp = 0;
    #1;
    checkOutput("C dir change cout", 32'(cCout), 0);
    for (int i = 8; i >= 0; i--) begin
      applyStimulus();
      checkOutput("C dn cnt", 32'(cCnt), 32'(i));
    end
    checkOutput("C dn cout at 0", 32'(cCout), 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("C sat hold 0", 32'(cCnt), 0);
    end
    cEn = 0;

    // Async reset mid-count on dutB: get ovf set, count to 7, pulse rst.
    bLoad = 1; bLoadVal = 4'd9;
    applyStimulus();
    bLoad = 0; bEn = 1; bUp = 1;
    applyStimulus();
    checkOutput("B pre-rst ovf", 32'(bOvf), 1);
    for (int i = 0; i < 7; i++) applyStimulus();
    checkOutput("B pre-rst cnt", 32'(bCnt), 7);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("B async cnt", 32'(bCnt), 0);
    checkOutput("B async ovf", 32'(bOvf), 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("B after rst cnt", 32'(bCnt), 0);
    applyStimulus();
    checkOutput("B resume 1", 32'(bCnt), 1);
    applyStimulus();
    checkOutput("B resume 2", 32'(bCnt), 2);
    bEn = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mod_counter
